// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module : adder_pkg
// Desc   : Shared types and constants for the digit-serial adder.
//          The BCD correction constant is consumed only when ADDER_BCD_EN is
//          defined.
// Rev    : 1.0  initial release
// ============================================================================
package adder_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of one processed digit
  localparam int DIGIT_W = 4;

  // Decimal adjust added to a digit sum that exceeds 9
  localparam logic [3:0] BCD_CORR = 4'd6;

endpackage
`default_nettype wire

// File: rtl/digit_add.sv
`default_nettype none
// ============================================================================
// Module : digit_add
// Desc   : Combinational single-digit adder: 4-bit + 4-bit + carry-in giving
//          a 4-bit digit and a carry-out. With ADDER_BCD_EN defined the digit
//          is decimal-adjusted (packed BCD); otherwise it is a binary nibble.
// Rev    : 1.0  initial release
// ============================================================================
module digit_add
  import adder_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] sum,
  output logic               cout
);

  logic [DIGIT_W:0] w_raw;

  // Raw 5-bit digit sum, then optional decimal adjustment
  always_comb begin
    w_raw = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
`ifdef ADDER_BCD_EN
    // Sum above 9 wraps past a decimal digit: add 6 and keep the low nibble
    if (w_raw > (DIGIT_W + 1)'(9)) begin
      sum  = w_raw[DIGIT_W-1:0] + BCD_CORR;
      cout = 1'b1;
    end else begin
      sum  = w_raw[DIGIT_W-1:0];
      cout = 1'b0;
    end
`else
    sum  = w_raw[DIGIT_W-1:0];
    cout = w_raw[DIGIT_W];
`endif
  end

endmodule
`default_nettype wire

// File: rtl/digit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module : digit_serial_adder
// Desc   : Multi-cycle WIDTH-bit adder with carry-in. One 4-bit digit is
//          added per clock, LSD first, using a single time-shared digit_add.
//          start/busy/done handshake; s updates only on completion.
//          Optional macro ADDER_BCD_EN selects packed-BCD digit arithmetic.
// Rev    : 1.0  initial release
// ============================================================================
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             c_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   s
);

  localparam int NDIG  = WIDTH / DIGIT_W;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   acc;

  logic [DIGIT_W-1:0] w_da;
  logic [DIGIT_W-1:0] w_db;
  logic [DIGIT_W-1:0] w_dsum;
  logic               w_dcout;
  logic [WIDTH-1:0]   w_acc_next;

  // Select the current operand digits and merge the new digit into the accumulator
  always_comb begin
    w_da       = a_q[idx*DIGIT_W +: DIGIT_W];
    w_db       = b_q[idx*DIGIT_W +: DIGIT_W];
    w_acc_next = acc;
    w_acc_next[idx*DIGIT_W +: DIGIT_W] = w_dsum;
  end

  digit_add u_digit_add (
    .a    (w_da),
    .b    (w_db),
    .cin  (carry),
    .sum  (w_dsum),
    .cout (w_dcout)
  );

  // Sequencer: accept in IDLE/DONE, one digit per RUN cycle, publish on last digit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      acc   <= '0;
      s     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            carry <= c_in;
            idx   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= w_acc_next;
          carry <= w_dcout;
          if (idx == LAST_IDX) begin
            s     <= {w_dcout, w_acc_next};
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module : tb_digit_serial_adder
// Desc   : Self-checking bench for digit_serial_adder (WIDTH=8). Honours
//          ADDER_BCD_EN for the expected values.
// Rev    : 1.0  initial release
// ============================================================================
module tb_digit_serial_adder;

  localparam int WIDTH = 8;
  localparam int NDIG  = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             c_in = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   s;

  int n_checks = 0;
  int n_err    = 0;

  digit_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .c_in  (c_in),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .s     (s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vc;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: plain arithmetic on whole numbers
  function automatic logic [8:0] ref_sum(input logic [7:0] x, input logic [7:0] y, input logic ci);
`ifdef ADDER_BCD_EN
    int dx, dy, t;
    dx = int'(x[7:4]) * 10 + int'(x[3:0]);
    dy = int'(y[7:4]) * 10 + int'(y[3:0]);
    t  = dx + dy + int'(ci);
    return {(t >= 100), 4'((t % 100) / 10), 4'(t % 10)};
`else
    return 9'({1'b0, x}) + 9'({1'b0, y}) + 9'(ci);
`endif
  endfunction

  function automatic logic [7:0] rand_op();
`ifdef ADDER_BCD_EN
    return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
`else
    return 8'($urandom);
`endif
  endfunction

  // One operation with a single-cycle start pulse; checks handshake timing and result
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                        input logic [8:0] exp, input string nm);
    int lat;
    int busy_cnt;
    @(negedge clk);
    a = ta; b = tb_; c_in = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = rand_op(); b = rand_op(); c_in = 1'($urandom);
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      check({nm, "_excl"}, {31'd0, busy & done}, 32'd0);
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check({nm, "_busy"}, busy_cnt, NDIG);
    check({nm, "_lat"}, lat, NDIG + 1);
    check({nm, "_s"}, 32'(s), 32'(exp));
  endtask

  initial begin
    // ---------------- reset state ----------------
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- table vectors ----------------
`ifdef ADDER_BCD_EN
    vecs.push_back('{8'h45, 8'h38, 1'b0, 9'h083});
    vecs.push_back('{8'h99, 8'h01, 1'b0, 9'h100});
    vecs.push_back('{8'h99, 8'h99, 1'b1, 9'h199});
    vecs.push_back('{8'h00, 8'h00, 1'b1, 9'h001});
    vecs.push_back('{8'h27, 8'h15, 1'b0, 9'h042});
`else
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 9'h100});
    vecs.push_back('{8'h00, 8'h00, 1'b1, 9'h001});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 9'h1FF});
    vecs.push_back('{8'h12, 8'h34, 1'b0, 9'h046});
    vecs.push_back('{8'h0F, 8'h01, 1'b0, 9'h010});
`endif
    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].exp, $sformatf("vec%0d", i));

    // ---------------- randomized operations ----------------
    for (int i = 0; i < 20; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = rand_op(); rb = rand_op(); rc = 1'($urandom);
      run_op(ra, rb, rc, ref_sum(ra, rb, rc), $sformatf("rnd%0d", i));
    end

    // ---------------- start during RUN is ignored ----------------
    begin
      int ndone;
      @(negedge clk);
      a = 8'h21; b = 8'h13; c_in = 1'b0; start = 1'b1;
      @(negedge clk);
      a = 8'h55; b = 8'h44; c_in = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      for (int k = 0; k < 8; k++) begin
        if (done) ndone++;
        @(negedge clk);
      end
      check("ign_ndone", ndone, 1);
      check("ign_s", 32'(s), 32'(ref_sum(8'h21, 8'h13, 1'b0)));
    end

    // ---------------- start held high ----------------
    begin
      logic [7:0] oa[0:15];
      logic [7:0] ob[0:15];
      logic       oc[0:15];
      logic [8:0] last_s;
      last_s = s;
      @(negedge clk);
      oa[0] = rand_op(); ob[0] = rand_op(); oc[0] = 1'($urandom);
      a = oa[0]; b = ob[0]; c_in = oc[0]; start = 1'b1;
      for (int m = 1; m <= 12; m++) begin
        @(negedge clk);
        check($sformatf("hold_done%0d", m), 32'(done), 32'((m % (NDIG + 1)) == 0));
        if ((m % (NDIG + 1)) == 0)
          last_s = ref_sum(oa[m - NDIG - 1], ob[m - NDIG - 1], oc[m - NDIG - 1]);
        check($sformatf("hold_s%0d", m), 32'(s), 32'(last_s));
        oa[m] = rand_op(); ob[m] = rand_op(); oc[m] = 1'($urandom);
        a = oa[m]; b = ob[m]; c_in = oc[m];
        if (m == 12) start = 1'b0;
      end
      @(negedge clk);
      check("hold_idle_busy", 32'(busy), 32'd0);
    end

    // ---------------- reset mid-RUN ----------------
    begin
      int ndone;
      run_op(8'h11, 8'h22, 1'b0, ref_sum(8'h11, 8'h22, 1'b0), "pre_rst");
      @(negedge clk);
      a = 8'h33; b = 8'h44; c_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("arst_s", 32'(s), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (done) ndone++;
      end
      check("arst_nodone", ndone, 0);
      check("arst_hold_s", 32'(s), 32'd0);
      run_op(8'h09, 8'h08, 1'b1, ref_sum(8'h09, 8'h08, 1'b1), "post_rst");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
